// File: rtl/fifo_packet_reader_pkg.sv
// Shared types and constants for the FIFO packet reader.
package fifo_packet_reader_pkg;

  // Reader FSM: wait for a header, wait for its return, stream the payload.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    PAYLOAD  = 2'd2
  } reader_state_t;

  // Entries in the output buffer; the read-issue rule keeps occ+inflight at or below this.
  localparam int OUT_BUFFER_DEPTH = 2;

endpackage

// File: rtl/fifo_packet_reader_skid_buffer.sv
// Two-entry {data, first, last} buffer between FIFO returns and the output stream.
// The producer never pushes into a full buffer; it uses o_occ and o_pop to decide.
module stream_skid_buffer
  import fifo_packet_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_first,
  input  logic                  i_last,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_first,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic [1:0]            o_occ,
  output logic                  o_pop
);

  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] r_mem [OUT_BUFFER_DEPTH];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_occ;
  logic [EW-1:0] w_head;
  logic          w_push;

  assign w_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != 2'd0);
  assign o_pop   = o_valid & i_ready;
  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign w_push  = i_push & ((r_occ != 2'd2) | o_pop);
  assign o_occ   = r_occ;

  // Outputs read as zero when empty; the head entry holds while stalled.
  assign o_data  = o_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign o_last  = o_valid & w_head[DATA_WIDTH];
  assign o_first = o_valid & w_head[DATA_WIDTH+1];

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
      for (int i = 0; i < OUT_BUFFER_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_first, i_last, i_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (o_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, o_pop};
    end
  end

endmodule

// File: rtl/fifo_packet_reader.sv
// Drains length-prefixed packets from a 1-cycle-latency FIFO into a
// valid/ready stream with first/last markers.
// Stream handshake: a word transfers on a rising edge where m_valid & m_ready;
// while m_valid is high and m_ready low, m_data/m_first/m_last hold steady.
module fifo_packet_reader
  import fifo_packet_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LENGTH_WIDTH = 12,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fifo_empty,
  output logic                    fifo_read_enable,
  input  logic [DATA_WIDTH-1:0]   fifo_read_data,
  input  logic                    fifo_read_data_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_first,
  output logic                    m_last,
  output logic [LENGTH_WIDTH-1:0] packet_length,
  output logic                    busy,
  output logic                    length_error,
  output logic [COUNT_WIDTH-1:0]  packets_sent,
  output logic [COUNT_WIDTH-1:0]  length_errors,
  output logic [1:0]              dbg_state
);

  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  reader_state_t             r_state;
  reader_state_t             w_next_state;
  logic [LENGTH_WIDTH-1:0]   r_packet_length;
  logic [LENGTH_WIDTH-1:0]   r_reads_left;
  logic [LENGTH_WIDTH-1:0]   r_words_left;
  logic                      r_inflight;
  logic                      r_length_error;
  logic [COUNT_WIDTH-1:0]    r_packets_sent;
  logic [COUNT_WIDTH-1:0]    r_length_errors;

  logic [LENGTH_WIDTH-1:0]   w_hdr_len;
  logic                      w_hdr_valid;
  logic                      w_payload_ret;
  logic                      w_rd_en;
  logic [1:0]                w_occ;
  logic                      w_pop;
  logic [2:0]                w_pending;
  logic                      w_room;
  logic                      w_done;

  assign w_hdr_len     = fifo_read_data[LENGTH_WIDTH-1:0];
  assign w_hdr_valid   = (r_state == HDR_WAIT) & fifo_read_data_valid;
  // Returns seen in IDLE are stale reads from before a reset and are dropped.
  assign w_payload_ret = (r_state == PAYLOAD) & fifo_read_data_valid;
  // Words already claimed in the buffer after this edge must stay below the depth.
  assign w_pending     = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_room        = w_pending < (3'd2 + {2'b00, w_pop});
  assign w_done        = (r_state == PAYLOAD) & w_pop & m_last;

  stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_payload_ret),
    .i_data  (fifo_read_data),
    .i_first (r_words_left == r_packet_length),
    .i_last  (r_words_left == LEN_ONE),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_first (m_first),
    .o_last  (m_last),
    .i_ready (m_ready),
    .o_occ   (w_occ),
    .o_pop   (w_pop)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and read-issue decode.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_rd_en      = 1'b1;
          w_next_state = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (fifo_read_data_valid) begin
          w_next_state = (w_hdr_len == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        w_rd_en = !fifo_empty & (r_reads_left != '0) & w_room;
        if (w_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A read issued during reset would pop a word nobody is waiting for.
  assign fifo_read_enable = w_rd_en & !reset;

  // Header capture, payload counters, error pulse and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_packet_length <= '0;
      r_reads_left    <= '0;
      r_words_left    <= '0;
      r_inflight      <= 1'b0;
      r_length_error  <= 1'b0;
      r_packets_sent  <= '0;
      r_length_errors <= '0;
    end else begin
      r_inflight     <= fifo_read_enable;
      r_length_error <= w_hdr_valid & (w_hdr_len == '0);
      if (w_hdr_valid) begin
        if (w_hdr_len == '0) begin
          r_length_errors <= r_length_errors + CNT_ONE;
        end else begin
          r_packet_length <= w_hdr_len;
          r_reads_left    <= w_hdr_len;
          r_words_left    <= w_hdr_len;
        end
      end
      if (fifo_read_enable && (r_state == PAYLOAD)) r_reads_left <= r_reads_left - LEN_ONE;
      if (w_payload_ret) r_words_left <= r_words_left - LEN_ONE;
      if (w_done) r_packets_sent <= r_packets_sent + CNT_ONE;
    end
  end

  assign packet_length = r_packet_length;
  assign length_error  = r_length_error;
  assign packets_sent  = r_packets_sent;
  assign length_errors = r_length_errors;
  assign busy          = (r_state != IDLE) | m_valid;
  assign dbg_state     = r_state;

endmodule
